// File: rtl/bus_assert_mux.sv
// bus_assert_mux: registered priority mux onto the Address and Transfer buses,
// with per-bus contention pulse, sticky flag and saturating counter.
module bus_assert_mux #(
  parameter int WIDTH     = 16,
  parameter int NSRC      = 6,
  parameter bit KEEP_LAST = 1,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       assert_addr_n,
  input  logic [NSRC-1:0]       assert_xfer_n,
  input  logic                  contention_clr,
  output logic [WIDTH-1:0]      addr_bus,
  output logic [WIDTH-1:0]      xfer_bus,
  output logic                  addr_valid,
  output logic                  xfer_valid,
  output logic                  addr_contention,
  output logic                  xfer_contention,
  output logic                  addr_cont_sticky,
  output logic                  xfer_cont_sticky,
  output logic [CNT_W-1:0]      addr_cont_cnt,
  output logic [CNT_W-1:0]      xfer_cont_cnt
);
  logic [1:0][NSRC-1:0] act;
  assign act[0] = ~assert_addr_n;
  assign act[1] = ~assert_xfer_n;
  genvar b;
  for (b = 0; b < 2; b++) begin : g_bus
    logic [WIDTH-1:0] win, bus_q;
    logic [CNT_W-1:0] cnt_q;
    logic             any, multi, valid_q, pulse_q, sticky_q;
    // scan from the top so the lowest active index is the last one written
    always_comb begin
      win = '0;
      for (int i = NSRC - 1; i >= 0; i--)
        if (act[b][i]) win = src_data[i*WIDTH +: WIDTH];
    end
    assign any   = |act[b];
    assign multi = |(act[b] & (act[b] - NSRC'(1)));
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        bus_q    <= '0;
        valid_q  <= 1'b0;
        pulse_q  <= 1'b0;
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        bus_q    <= any ? win : (KEEP_LAST ? bus_q : '0);
        valid_q  <= any;
        pulse_q  <= multi;
        sticky_q <= multi | (sticky_q & ~contention_clr);
        cnt_q    <= contention_clr ? (multi ? CNT_W'(1) : '0)
                  : (multi && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
      end
  end
  assign addr_bus         = g_bus[0].bus_q;
  assign xfer_bus         = g_bus[1].bus_q;
  assign addr_valid       = g_bus[0].valid_q;
  assign xfer_valid       = g_bus[1].valid_q;
  assign addr_contention  = g_bus[0].pulse_q;
  assign xfer_contention  = g_bus[1].pulse_q;
  assign addr_cont_sticky = g_bus[0].sticky_q;
  assign xfer_cont_sticky = g_bus[1].sticky_q;
  assign addr_cont_cnt    = g_bus[0].cnt_q;
  assign xfer_cont_cnt    = g_bus[1].cnt_q;
endmodule
